// File: rtl/blink_sequencer.sv
// Tick-driven LED blink controller: plays a latched pattern of ON/OFF phases
// counted in time-base ticks. Outputs are Moore decodes of the state register.
module blink_sequencer #(
  parameter int TICK_W = 3,
  parameter int REP_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_tick,
  input  logic [TICK_W-1:0] i_on_ticks,
  input  logic [TICK_W-1:0] i_off_ticks,
  input  logic [REP_W-1:0]  i_repeat,
  output logic              o_led,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]        state;
  logic [TICK_W-1:0] on_lat;
  logic [TICK_W-1:0] off_lat;
  logic [REP_W-1:0]  rep_left;
  logic [TICK_W-1:0] tick_cnt;

  logic on_end;
  logic off_end;
  logic more_reps;

  // Handshake: i_start acts as a valid with an implicit ready of !o_busy; a
  // start is accepted on any edge where both are high and is dropped otherwise.
  assign on_end    = i_tick && (tick_cnt == on_lat - TICK_W'(1));
  assign off_end   = i_tick && (tick_cnt == off_lat - TICK_W'(1));
  assign more_reps = rep_left > REP_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      on_lat   <= '0;
      off_lat  <= '0;
      rep_left <= '0;
      tick_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            on_lat   <= i_on_ticks;
            off_lat  <= i_off_ticks;
            rep_left <= i_repeat;
            tick_cnt <= '0;
            if ((i_repeat == '0) || (i_on_ticks == '0)) state <= ST_DONE;
            else                                        state <= ST_ON;
          end
        end
        ST_ON: begin
          if (on_end) begin
            tick_cnt <= '0;
            if (off_lat != '0) begin
              state <= ST_OFF;
            end else if (more_reps) begin
              // Back-to-back blinks with no OFF phase keep the LED lit.
              rep_left <= rep_left - REP_W'(1);
              state    <= ST_ON;
            end else begin
              state <= ST_DONE;
            end
          end else if (i_tick) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        ST_OFF: begin
          if (off_end) begin
            tick_cnt <= '0;
            if (more_reps) begin
              rep_left <= rep_left - REP_W'(1);
              state    <= ST_ON;
            end else begin
              state <= ST_DONE;
            end
          end else if (i_tick) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        default: begin
          tick_cnt <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_led   = (state == ST_ON);
  assign o_busy  = (state != ST_IDLE);
  assign o_done  = (state == ST_DONE);
  assign o_state = state;

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed bench for blink_sequencer: hand-computed LED/busy/done traces held
// in an expected queue and compared with immediate assertions.
module tb_blink_sequencer;

  logic       i_clk;
  logic       i_rst;
  logic       i_start;
  logic       i_tick;
  logic [2:0] i_on_ticks;
  logic [2:0] i_off_ticks;
  logic [3:0] i_repeat;
  logic       o_led;
  logic       o_busy;
  logic       o_done;
  logic [1:0] o_state;

  int checks = 0;
  int errors = 0;

  // {led, busy, done} after each tick
  logic [2:0] exp_q[$];
  logic [2:0] prev;

  blink_sequencer #(.TICK_W(3), .REP_W(4)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_tick      (i_tick),
    .i_on_ticks  (i_on_ticks),
    .i_off_ticks (i_off_ticks),
    .i_repeat    (i_repeat),
    .o_led       (o_led),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_state     (o_state)
  );

  // clock/reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] exp);
    chk(tag, {5'd0, o_led, o_busy, o_done}, {5'd0, exp});
  endtask

  // Plays the queued expectations: gap tickless cycles (outputs must hold)
  // followed by one tick, after which the popped value must appear.
  task automatic run_ticks(input string tag, input int gap);
    logic [2:0] e;
    while (exp_q.size() > 0) begin
      for (int g = 0; g < gap; g++) begin
        step();
        chk_out({tag, "_hold"}, {prev[2:1], 1'b0});
      end
      i_tick = 1'b1;
      step();
      i_tick = 1'b0;
      e = exp_q.pop_front();
      chk_out({tag, "_tick"}, e);
      prev = e;
    end
  endtask

  task automatic start(input logic [2:0] on, input logic [2:0] off, input logic [3:0] rep,
                       input logic tick_with_start);
    i_on_ticks  = on;
    i_off_ticks = off;
    i_repeat    = rep;
    i_start     = 1'b1;
    i_tick      = tick_with_start;
    step();
    i_start = 1'b0;
    i_tick  = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_tick = 1'b0;
    i_on_ticks = 3'd0; i_off_ticks = 3'd0; i_repeat = 4'd0;

    // Reset held 3 cycles with start asserted and tick toggling
    i_start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      i_tick = c[0];
      step();
      chk_out("reset_outs", 3'b000);
      chk("reset_state", {6'd0, o_state}, 8'd0);
    end
    i_rst = 1'b0; i_start = 1'b0; i_tick = 1'b0;
    step();
    chk_out("idle_after_reset", 3'b000);

    // Basic: on=2 off=1 rep=2, tick coincident with start is ignored
    start(3'd2, 3'd1, 4'd2, 1'b1);
    chk_out("basic_start", 3'b110);
    chk("basic_state_on", {6'd0, o_state}, 8'd1);
    exp_q = '{3'b110, 3'b010, 3'b110, 3'b110, 3'b010, 3'b011};
    prev = 3'b110;
    run_ticks("basic", 3);
    step();
    chk_out("basic_idle", 3'b000);

    // off=0: on=3 rep=3 -> LED lit for 9 ticks, then DONE
    start(3'd3, 3'd0, 4'd3, 1'b0);
    chk_out("off0_start", 3'b110);
    for (int t = 0; t < 8; t++) exp_q.push_back(3'b110);
    exp_q.push_back(3'b011);
    prev = 3'b110;
    run_ticks("off0", 1);
    step();
    chk_out("off0_idle", 3'b000);

    // Degenerate: repeat=0
    start(3'd3, 3'd2, 4'd0, 1'b0);
    chk_out("rep0_done", 3'b011);
    step();
    chk_out("rep0_idle", 3'b000);

    // Degenerate: on=0 repeat=5
    start(3'd0, 3'd2, 4'd5, 1'b0);
    chk_out("on0_done", 3'b011);
    chk("on0_state", {6'd0, o_state}, 8'd3);
    step();
    chk_out("on0_idle", 3'b000);

    // Busy: on=2 off=2 rep=1 while start and inputs change underneath
    start(3'd2, 3'd2, 4'd1, 1'b0);
    i_start = 1'b1; i_on_ticks = 3'd7; i_off_ticks = 3'd0; i_repeat = 4'd9;
    exp_q = '{3'b110, 3'b010, 3'b010, 3'b011};
    prev = 3'b110;
    run_ticks("busy_latched", 0);
    // start still high in the cycle busy falls
    step();
    chk_out("busy_fall", 3'b000);
    step();
    chk_out("restart_accepted", 3'b110);
    i_start = 1'b0; i_on_ticks = 3'd1; i_off_ticks = 3'd1; i_repeat = 4'd1;
    // latched on=7 off=0 rep=9: seven ticks keep the LED lit and stay busy
    for (int t = 0; t < 7; t++) exp_q.push_back(3'b110);
    prev = 3'b110;
    run_ticks("restart_on7", 0);
    chk("restart_state", {6'd0, o_state}, 8'd1);

    // Reset mid-OFF of blink 2 of 4 (on=1 off=2)
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk_out("clear_between", 3'b000);
    start(3'd1, 3'd2, 4'd4, 1'b0);
    exp_q = '{3'b010, 3'b010, 3'b110, 3'b010};
    prev = 3'b110;
    run_ticks("pre_reset", 0);
    chk("mid_off_state", {6'd0, o_state}, 8'd2);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk_out("mid_off_reset", 3'b000);
    chk("mid_off_reset_state", {6'd0, o_state}, 8'd0);
    step();
    chk_out("no_done_after_reset", 3'b000);

    // Fresh pattern after reset: on=1 off=1 rep=2
    start(3'd1, 3'd1, 4'd2, 1'b0);
    chk_out("fresh_start", 3'b110);
    exp_q = '{3'b010, 3'b110, 3'b010, 3'b011};
    prev = 3'b110;
    run_ticks("fresh", 2);
    step();
    chk_out("fresh_idle", 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blink_sequencer.md
# blink_sequencer

Tick-driven LED blink controller for the blinking machine. Consumes the single-cycle timeout pulse from the period counter as its time base and plays a programmed pattern: a number of blinks, each with an ON phase and an OFF phase measured in ticks. Emits the LED drive, a busy flag and a one-cycle completion pulse. All outputs are Moore decodes of registered state.

## Interface
- TICK_W, 3: width of the ON/OFF phase lengths, in ticks.
- REP_W, 4: width of the blink repeat count.

- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  request to start a pattern; sampled only in IDLE.
- i_tick  in  1  time-base pulse, one cycle wide, from the period counter.
- i_on_ticks  in  TICK_W  ON phase length in ticks; latched on start.
- i_off_ticks  in  TICK_W  OFF phase length in ticks; latched on start.
- i_repeat  in  REP_W  number of blinks; latched on start.
- o_led  out  1  LED drive; high only in ON.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse in DONE.

## Operation
- States: IDLE, ON, OFF, DONE. The state register and all counters are cleared by i_rst.
- Internal registers:
  - on_lat, off_lat (TICK_W) and rep_left (REP_W): configuration latched on start.
  - tick_cnt (TICK_W): ticks counted in the current phase. It is cleared on every state entry.
- IDLE:
  - Start is accepted when i_start=1. On acceptance, latch the configuration and clear tick_cnt.
  - If i_repeat==0 or i_on_ticks==0, go to DONE. No LED activity occurs.
  - Otherwise go to ON.
- ON, when i_tick=1:
  - If tick_cnt==on_lat-1, the phase ends.
  - Otherwise tick_cnt increments.
- End of ON:
  - If off_lat!=0, go to OFF.
  - If off_lat==0 and rep_left>1, decrement rep_left and go back to ON. o_led stays high.
  - If off_lat==0 and rep_left==1, go to DONE.
- OFF, when i_tick=1:
  - If tick_cnt==off_lat-1, the phase ends.
  - Otherwise tick_cnt increments.
- End of OFF:
  - If rep_left>1, decrement rep_left and go to ON.
  - Otherwise go to DONE.
- DONE: lasts exactly one cycle, then goes to IDLE unconditionally.
- While busy:
  - i_start is ignored.
  - Changes on i_on_ticks, i_off_ticks and i_repeat have no effect; only latched values are used.
- Cycles without i_tick never advance tick_cnt. A phase of length N ends on the N-th tick received in that phase.
- Every blink, including the last, has a full OFF phase when off_lat!=0.
- The maximum programmable phase is 2^TICK_W-1 ticks. The maximum repeat count is 2^REP_W-1. There is no wrap-around, because compares are exact.

## Timing
- Reset values: o_led=0, o_busy=0, o_done=0, state=IDLE.
- Reset has priority over every other input in the same cycle. A reset during ON drops o_led on the next edge.
- Start latency: i_start sampled at edge k gives o_led=1 and o_busy=1 after edge k.
- A tick present in the same cycle as the accepted i_start is ignored. Counting begins in the first cycle in ON.
- Phase end: the terminating tick sampled at edge m updates state and o_led after edge m, with no extra cycle.
- Completion: o_done=1 for exactly one cycle with o_busy=1. The next cycle has o_busy=0, and a new i_start is accepted from that cycle on.
- Degenerate start (repeat==0 or on_ticks==0): o_done pulses in the cycle after start, and o_led is never asserted.

## Test plan
- Reset: hold i_rst for 3 cycles with i_start=1 and i_tick toggling -> o_led=0, o_busy=0, o_done=0 throughout.
- Basic pattern: on=2, off=1, repeat=2, with a tick every 4 cycles -> o_led high for 2 ticks, low for 1, high for 2, low for 1. o_done pulses once, in the cycle after the 6th counted tick. o_busy then falls.
- off=0: on=3, repeat=3 -> o_led high continuously for 9 ticks. One o_done follows.
- Degenerate starts:
  - repeat=0 -> o_done in the cycle after start, o_led never high.
  - on=0, repeat=5 -> same behaviour.
- Busy interaction:
  - Re-assert i_start and change the inputs mid-pattern -> the pattern follows the original latched values.
  - A start presented in the cycle o_busy falls -> accepted, o_led=1 next edge.
- Reset mid-OFF of blink 2 of 4 -> all outputs return to reset values next edge, with no o_done. A fresh start then runs a full pattern.
